osc_line_scanner: RTL and testbench

- Parametrised successor to the top-level oscilloscope serialiser. Scans a full display store (N_LINES words of WORD_LENGTH bits) onto the single OSC output pin.
- Each bit is held for a programmable bit period. Programmable blank gaps separate lines.
- Line-sync and frame-sync strobes are provided for the scope trigger.
- The store is snapshotted at frame start, so a frame is never torn by CPU writes. Sits between the processor's display store output and the OSC pad.

---
 rtl/osc_line_scanner.sv | 193 +++++++++++++++++++
 tb/tb_osc_line_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_line_scanner.sv
// Scans a snapshot of the display store, line by line and LSB first, onto the OSC pin.
// Define OSC_DOTDASH_EN to shape each bit period as a Williams-tube dot (0) or dash (1).
module osc_line_scanner #(
    parameter int WORD_LENGTH = 32,
    parameter int N_LINES     = 32,
    parameter int CLK_DIV     = 4,
    parameter int GAP_BITS    = 1,
    parameter int SYNC_BITS   = 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           EN,
    input  logic [N_LINES*WORD_LENGTH-1:0] b_FRAME,
    output logic                           OSC,
    output logic                           OSC_LINE_SYNC,
    output logic                           OSC_FRAME_SYNC,
    output logic                           FRAME_DONE,
    output logic [$clog2(N_LINES):0]       LINE_IDX,
    output logic [$clog2(WORD_LENGTH):0]   BIT_IDX,
    output logic                           BUSY
);
    localparam int LW = $clog2(N_LINES) + 1;
    localparam int BW = $clog2(WORD_LENGTH) + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(SYNC_BITS + GAP_BITS + 1) + 1;

`ifdef OSC_DOTDASH_EN
    localparam int QD = CLK_DIV / 4;
    if (CLK_DIV % 4 != 0) begin : g_clk_div_check
        $error("osc_line_scanner: CLK_DIV must be a multiple of 4 for dot/dash output");
    end
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [PW-1:0]                  per_q, per_d;
    logic [LW-1:0]                  line_q, line_d;
    logic [BW-1:0]                  bit_q, bit_d;
    logic [N_LINES*WORD_LENGTH-1:0] shadow_q, shadow_d;
    logic                           osc_q, line_sync_q, frame_sync_q, frame_done_q, busy_q;
    logic [LW-1:0]                  line_idx_q;
    logic [BW-1:0]                  bit_idx_q;
    logic                           tick_s, last_bit_s, last_line_s, gap_last_s;
    logic                           frame_end_s, snap_s, osc_s, data_bit_s;
    logic [WORD_LENGTH-1:0]         line_word_s;

    // Position decodes shared by the sequencer and the output logic.
    always_comb begin
        tick_s      = (cnt_q == CW'(CLK_DIV - 1));
        last_bit_s  = (bit_q == BW'(WORD_LENGTH - 1));
        last_line_s = (line_q == LW'(N_LINES - 1));
        gap_last_s  = (per_q == PW'(GAP_BITS - 1));
        frame_end_s = tick_s && last_line_s &&
                      ((GAP_BITS == 0) ? ((state_q == DATA) && last_bit_s)
                                       : ((state_q == GAP) && gap_last_s));
        snap_s      = EN && ((state_q == IDLE) || frame_end_s);
    end

    // Sequencer next-state: tick counter, period/bit/line counters and the frame snapshot.
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        line_d   = line_q;
        bit_d    = bit_q;
        shadow_d = snap_s ? b_FRAME : shadow_q;
        if ((state_q == IDLE) || tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = SYNC;
                    per_d   = '0;
                    line_d  = '0;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (tick_s && (per_q == PW'(SYNC_BITS - 1))) begin
                    state_d = DATA;
                    per_d   = '0;
                end else if (tick_s) begin
                    per_d = per_q + PW'(1);
                end else begin
                    per_d = per_q;
                end
            end
            DATA: begin
                if (tick_s && !last_bit_s) begin
                    bit_d = bit_q + BW'(1);
                end else if (tick_s && frame_end_s) begin
                    bit_d   = '0;
                    line_d  = '0;
                    state_d = EN ? SYNC : IDLE;
                end else if (tick_s && (GAP_BITS > 0)) begin
                    bit_d   = '0;
                    state_d = GAP;
                end else if (tick_s) begin
                    bit_d  = '0;
                    line_d = line_q + LW'(1);
                end else begin
                    bit_d = bit_q;
                end
            end
            GAP: begin
                if (tick_s && !gap_last_s) begin
                    per_d = per_q + PW'(1);
                end else if (tick_s && frame_end_s) begin
                    per_d   = '0;
                    line_d  = '0;
                    state_d = EN ? SYNC : IDLE;
                end else if (tick_s) begin
                    per_d   = '0;
                    line_d  = line_q + LW'(1);
                    state_d = DATA;
                end else begin
                    per_d = per_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Video level for the current cycle; it reaches the pin one edge later.
    always_comb begin
        line_word_s = shadow_q[int'(line_q)*WORD_LENGTH +: WORD_LENGTH];
        data_bit_s  = line_word_s[bit_q[BW-2:0]];
        if (state_q == DATA) begin
`ifdef OSC_DOTDASH_EN
            osc_s = data_bit_s ? (cnt_q < CW'(3*QD)) : (cnt_q < CW'(QD));
`else
            osc_s = data_bit_s;
`endif
        end else begin
            osc_s = 1'b0;
        end
    end

    // State registers and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_q        <= '0;
            line_q       <= '0;
            bit_q        <= '0;
            shadow_q     <= '0;
            osc_q        <= 1'b0;
            line_sync_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            line_idx_q   <= '0;
            bit_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            line_q       <= line_d;
            bit_q        <= bit_d;
            shadow_q     <= shadow_d;
            osc_q        <= osc_s;
            line_sync_q  <= (state_q == DATA) && (bit_q == '0) && (cnt_q == '0);
            frame_sync_q <= (state_q == SYNC) && (per_q == '0) && (cnt_q == '0);
            frame_done_q <= frame_end_s;
            busy_q       <= (state_q != IDLE);
            line_idx_q   <= line_q;
            bit_idx_q    <= bit_q;
        end
    end

    assign OSC            = osc_q;
    assign OSC_LINE_SYNC  = line_sync_q;
    assign OSC_FRAME_SYNC = frame_sync_q;
    assign FRAME_DONE     = frame_done_q;
    assign BUSY           = busy_q;
    assign LINE_IDX       = line_idx_q;
    assign BIT_IDX        = bit_idx_q;

endmodule

// File: tb/tb_osc_line_scanner.sv
// Bench for osc_line_scanner: two configurations checked cycle by cycle against a frame model
// built directly from the scan rules (sync, LSB-first lines, gaps, one-cycle output latency).
module tb_osc_line_scanner;
`ifdef OSC_DOTDASH_EN
    localparam int DA = 4;
    localparam int DB = 4;
    localparam bit DD = 1'b1;
`else
    localparam int DA = 2;
    localparam int DB = 1;
    localparam bit DD = 1'b0;
`endif
    localparam int WA = 4, NA = 2, GA = 1, SA = 1;
    localparam int WB = 4, NB = 3, GB = 0, SB = 2;
    localparam int FA = (SA + NA*(WA+GA))*DA;
    localparam int FB = (SB + NB*(WB+GB))*DB;

    // v = {osc, line_sync, frame_sync, frame_done, busy}
    typedef struct {
        logic [4:0] v;
        int         line;
        int         bitn;
        bit         data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0, rst_n = 1'b0, en_a = 1'b0, en_b = 1'b0;
    logic [NA*WA-1:0] frame_a = '0;
    logic [NB*WB-1:0] frame_b = '0;
    logic osc_a, ls_a, fs_a, fd_a, busy_a;
    logic osc_b, ls_b, fs_b, fd_b, busy_b;
    logic [$clog2(NA):0] line_a;
    logic [$clog2(WA):0] bit_a;
    logic [$clog2(NB):0] line_b;
    logic [$clog2(WB):0] bit_b;

    always #5 clk = ~clk;

    osc_line_scanner #(.WORD_LENGTH(WA), .N_LINES(NA), .CLK_DIV(DA), .GAP_BITS(GA), .SYNC_BITS(SA)) dut_a (
        .CLK(clk), .RST_N(rst_n), .EN(en_a), .b_FRAME(frame_a), .OSC(osc_a),
        .OSC_LINE_SYNC(ls_a), .OSC_FRAME_SYNC(fs_a), .FRAME_DONE(fd_a),
        .LINE_IDX(line_a), .BIT_IDX(bit_a), .BUSY(busy_a));

    osc_line_scanner #(.WORD_LENGTH(WB), .N_LINES(NB), .CLK_DIV(DB), .GAP_BITS(GB), .SYNC_BITS(SB)) dut_b (
        .CLK(clk), .RST_N(rst_n), .EN(en_b), .b_FRAME(frame_b), .OSC(osc_b),
        .OSC_LINE_SYNC(ls_b), .OSC_FRAME_SYNC(fs_b), .FRAME_DONE(fd_b),
        .LINE_IDX(line_b), .BIT_IDX(bit_b), .BUSY(busy_b));

    function automatic void push(input logic [4:0] v, input int l, input int b, input bit d);
        exp_t e;
        e.v = v; e.line = l; e.bitn = b; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void add_idle(input int n);
        for (int k = 0; k < n; k++) push(5'b00000, 0, 0, 1'b0);
    endfunction

    // One frame as seen on the pins: sync blanks, each line LSB first, gap blanks, done on last cycle.
    function automatic void add_frame(input int w, input int n, input int d, input int g, input int s,
                                      input logic [63:0] fr);
        exp_t e;
        logic o;
        for (int c = 0; c < s*d; c++) push({1'b0, 1'b0, (c == 0), 1'b0, 1'b1}, 0, 0, 1'b0);
        for (int l = 0; l < n; l++) begin
            for (int b = 0; b < w; b++) begin
                for (int c = 0; c < d; c++) begin
                    if (DD) o = fr[l*w+b] ? (c < 3*d/4) : (c < d/4);
                    else    o = fr[l*w+b];
                    push({o, (b == 0 && c == 0), 1'b0, 1'b0, 1'b1}, l, b, 1'b1);
                end
            end
            for (int c = 0; c < g*d; c++) push(5'b00001, l, 0, 1'b0);
        end
        e = exp_q.pop_back();
        e.v[1] = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Consume the expectation queue, one entry per clock, optionally changing the store or dropping EN.
    task automatic play(input int which, input int chg_at, input logic [63:0] chg_val, input int en_off_at);
        exp_t e;
        logic [4:0] obs;
        integer li, bi;
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            if (which == 0) begin
                obs = {osc_a, ls_a, fs_a, fd_a, busy_a}; li = line_a; bi = bit_a;
            end else begin
                obs = {osc_b, ls_b, fs_b, fd_b, busy_b}; li = line_b; bi = bit_b;
            end
            n_tests++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL outputs dut%0d cycle %0d observed %b expected %b", which, i, obs, e.v);
            end
            if (e.data) begin
                n_tests++;
                assert (li === e.line && bi === e.bitn) else begin
                    n_fail++;
                    $error("FAIL index dut%0d cycle %0d observed line %0d bit %0d expected line %0d bit %0d",
                           which, i, li, bi, e.line, e.bitn);
                end
            end
            if (i == chg_at) begin
                if (which == 0) frame_a = chg_val[NA*WA-1:0];
                else            frame_b = chg_val[NB*WB-1:0];
            end
            if (i == en_off_at) begin
                if (which == 0) en_a = 1'b0;
                else            en_b = 1'b0;
            end
            i++;
        end
    endtask

    initial begin
        logic [63:0] r1, r2;
        logic [31:0] allout;

        repeat (3) @(posedge clk);
        #1;
        allout = {osc_a, ls_a, fs_a, fd_a, busy_a, line_a, bit_a, osc_b, ls_b, fs_b, fd_b, busy_b, line_b, bit_b};
        n_tests++;
        assert (allout === 32'd0) else begin
            n_fail++;
            $error("FAIL reset_state observed %h expected 0", allout);
        end
        rst_n = 1'b1;

        // Directed frame 8'b1010_0011: lines 1,1,0,0 and 0,1,0,1 with a one-cycle EN pulse.
        @(posedge clk); #1;
        frame_a = 8'b1010_0011;
        en_a = 1'b1;
        add_idle(1); add_frame(WA, NA, DA, GA, SA, 64'(frame_a)); add_idle(3);
        play(0, -1, 64'd0, 0);

        // Random frames; EN released at a random point inside the frame.
        for (int k = 0; k < 4; k++) begin
            r1 = {$urandom, $urandom};
            frame_a = r1[NA*WA-1:0];
            en_a = 1'b1;
            add_idle(1); add_frame(WA, NA, DA, GA, SA, 64'(frame_a)); add_idle(2);
            play(0, -1, 64'd0, int'($urandom_range(0, FA-1)));
        end

        // Snapshot coherency over back-to-back frames: ones stay ones, next frame sees zeros.
        frame_a = 8'hFF;
        en_a = 1'b1;
        add_idle(1); add_frame(WA, NA, DA, GA, SA, 64'hFF); add_frame(WA, NA, DA, GA, SA, 64'h00); add_idle(3);
        play(0, SA*DA+3, 64'h00, FA);

        for (int k = 0; k < 2; k++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            frame_a = r1[NA*WA-1:0];
            en_a = 1'b1;
            add_idle(1); add_frame(WA, NA, DA, GA, SA, 64'(r1[NA*WA-1:0]));
            add_frame(WA, NA, DA, GA, SA, 64'(r2[NA*WA-1:0])); add_idle(2);
            play(0, SA*DA+3, r2, FA);
        end

        // No gap, one clock per bit: lines abut and line sync repeats every WORD_LENGTH bits.
        for (int k = 0; k < 3; k++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            frame_b = r1[NB*WB-1:0];
            en_b = 1'b1;
            add_idle(1); add_frame(WB, NB, DB, GB, SB, 64'(r1[NB*WB-1:0]));
            add_frame(WB, NB, DB, GB, SB, 64'(r2[NB*WB-1:0])); add_idle(2);
            play(1, SB*DB+1, r2, FB);
        end

        // Reset in the middle of line 0 with EN held high.
        r1 = {$urandom, $urandom};
        frame_a = r1[NA*WA-1:0];
        en_a = 1'b1;
        repeat (SA*DA+4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        allout = {osc_a, ls_a, fs_a, fd_a, busy_a, line_a, bit_a, osc_b, ls_b, fs_b, fd_b, busy_b, line_b, bit_b};
        n_tests++;
        assert (allout === 32'd0) else begin
            n_fail++;
            $error("FAIL mid_frame_reset observed %h expected 0", allout);
        end
        en_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            n_tests++;
            assert ({osc_a, fs_a, fd_a, busy_a} === 4'b0000) else begin
                n_fail++;
                $error("FAIL idle_hold cycle %0d observed %b expected 0000", k, {osc_a, fs_a, fd_a, busy_a});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
